data_memory_lsu: RTL and testbench

//   Parametrised, handshaked data-memory controller for the RV32I datapath: services LB/LBU/LH/LHU/LW/SB/SH/SW.

---
 rtl/types_pkg.sv | 48 ++++
 rtl/dmem_ram_be.sv | 33 +++
 rtl/data_memory_lsu.sv | 161 ++++++++++++++++
 tb/tb_data_memory_lsu.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the RV32I data-memory load/store unit: access sizes,
// controller states, latched-request record and byte-lane helpers.
package types_pkg;

    localparam int BYTE_LANES = 4;

    // Access size as carried on req_size; encoding 2'd3 is treated as Word.
    typedef enum logic [1:0] {
        Byte = 2'd0,
        Half = 2'd1,
        Word = 2'd2
    } byte_format;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        RESP  = 2'd2
    } lsu_state_t;

    // Request fields kept for the beats and the response after acceptance.
    typedef struct packed {
        logic       we;
        logic       sgn;
        byte_format size;
        logic [1:0] off;
        logic       crossing;
        logic       err;
    } lsu_req_t;

    // Lane mask of an access starting at lane 0.
    function automatic logic [BYTE_LANES-1:0] size_mask(input byte_format size);
        case (size)
            Byte:    size_mask = 4'b0001;
            Half:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

    // Number of bytes touched by an access.
    function automatic logic [2:0] size_bytes(input byte_format size);
        case (size)
            Byte:    size_bytes = 3'd1;
            Half:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Single-port data RAM: DEPTH_WORDS x 32 bits, synchronous read (read-first),
// per-byte write enables. INIT_FILE is accepted for interface compatibility.
module dmem_ram_be #(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = "",
    parameter int    AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane write and registered read of the addressed word.
    // NOTE: the storage array has no reset; clearing it would need a
    // DEPTH_WORDS-cycle sweep and RAM macros cannot be reset anyway.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_lsu.sv
// Handshaked data-memory controller for the RV32I MEM stage: LB/LBU/LH/LHU/LW
// and SB/SH/SW with byte-lane writes, registered response and error flag.
// Build option: DMEM_MISALIGN_SPLIT_EN -- when defined, word-crossing accesses
// are split into two RAM beats; otherwise they are rejected with rsp_err.
module data_memory_lsu
    import types_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    ADDR_W      = 32,
    parameter string INIT_FILE   = ""
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_signed_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Word index with one spare MSB so that index+1 never wraps to 0.
    localparam int IW = ADDR_W - 1;
    localparam logic [IW-1:0] DEPTH_IDX = IW'(DEPTH_WORDS);

    lsu_state_t state_q, state_d;
    lsu_req_t   req_q, req_d;

    logic [AW-1:0] idx1_q;
    logic [3:0]    hi_be_q;
    logic [31:0]   hi_data_q;
    logic [31:0]   word0_q;

    logic          accept;
    byte_format    size;
    logic [1:0]    offset;
    logic [IW-1:0] idx0, idx1;
    logic          crossing, err_range, err_acc, go_split;
    logic [7:0]    mask8;
    logic [63:0]   wdata64;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [31:0]   word_lo, word_hi, load_word;

    // ---------------- request decode ----------------
    assign req_ready_o = (state_q != SPLIT);
    assign accept      = req_valid_i && req_ready_o;
    assign size        = byte_format'(req_size_i);
    assign offset      = req_addr_i[1:0];
    assign idx0        = {1'b0, req_addr_i[ADDR_W-1:2]};
    assign idx1        = idx0 + IW'(1);
    assign crossing    = ({1'b0, offset} + size_bytes(size)) > 3'd4;
    assign err_range   = (idx0 >= DEPTH_IDX) || (crossing && (idx1 >= DEPTH_IDX));

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign err_acc  = err_range;
    assign go_split = crossing && !err_range;
`else
    assign err_acc  = err_range || crossing;
    assign go_split = 1'b0;
`endif

    // Lanes and data of both beats, as one 64-bit window over {word1, word0}.
    assign mask8   = 8'({4'b0000, size_mask(size)} << offset);
    assign wdata64 = {32'b0, req_wdata_i} << {offset, 3'b000};

    // ---------------- RAM port ----------------
    assign ram_addr  = (state_q == SPLIT) ? idx1_q    : idx0[AW-1:0];
    assign ram_be    = (state_q == SPLIT) ? hi_be_q   : mask8[3:0];
    assign ram_wdata = (state_q == SPLIT) ? hi_data_q : wdata64[31:0];
    // Reset blocks both beats; an erroneous request never writes.
    assign ram_we    = !rst_i && ((state_q == SPLIT) ? req_q.we
                                                     : (accept && req_we_i && !err_acc));

    dmem_ram_be #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE),
        .AW          (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // ---------------- FSM ----------------
    // Next state and latched request; an accept is possible from IDLE and RESP.
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    req_d = '{we: req_we_i, sgn: req_signed_i, size: size,
                              off: offset, crossing: crossing, err: err_acc};
                    state_d = go_split ? SPLIT : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            SPLIT:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    // State and request registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Beat-1 write data/lanes/index and the beat-0 read word for split accesses.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx1_q    <= idx1[AW-1:0];
            hi_be_q   <= mask8[7:4];
            hi_data_q <= wdata64[63:32];
        end
        if (state_q == SPLIT) word0_q <= ram_rdata;
    end

    // ---------------- response ----------------
    assign word_lo   = req_q.crossing ? word0_q   : ram_rdata;
    assign word_hi   = req_q.crossing ? ram_rdata : 32'b0;
    assign load_word = 32'({word_hi, word_lo} >> {req_q.off, 3'b000});

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_err_o   = (state_q == RESP) && req_q.err;

    // Load result: truncate to size, then sign- or zero-extend; 0 otherwise.
    always_comb begin
        rsp_rdata_o = '0;
        if ((state_q == RESP) && !req_q.we && !req_q.err) begin
            case (req_q.size)
                Byte:    rsp_rdata_o = {{24{req_q.sgn & load_word[7]}},  load_word[7:0]};
                Half:    rsp_rdata_o = {{16{req_q.sgn & load_word[15]}}, load_word[15:0]};
                default: rsp_rdata_o = load_word;
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed self-checking bench for data_memory_lsu (both build options).
module tb_data_memory_lsu;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] r_data;
    logic        r_err;
    logic        r_got;
    int          r_lat;

    always #5 clk = ~clk;

    data_memory_lsu #(.DEPTH_WORDS(1024), .ADDR_W(32), .INIT_FILE("")) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_size_i   (req_size),
        .req_signed_i (req_signed),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction: drive at negedge, accepted at the next posedge, then
    // wait (bounded) for the response strobe and capture it.
    task automatic xact(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_we = we; req_size = sz; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        r_lat = 1;
        while (!rsp_valid && r_lat < 5) begin
            @(posedge clk);
            #1;
            r_lat++;
        end
        r_got  = rsp_valid;
        r_data = rsp_rdata;
        r_err  = rsp_err;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] data,
                              input logic err, input int lat);
        check({tag, ".valid"}, 32'(r_got), 32'd1);
        check({tag, ".data"},  r_data, data);
        check({tag, ".err"},   32'(r_err), 32'(err));
        check({tag, ".lat"},   32'(r_lat), 32'(lat));
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_W;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.ready", 32'(req_ready), 32'd1);
        check("reset.valid", 32'(rsp_valid), 32'd0);
        check("reset.rdata", rsp_rdata, 32'd0);
        check("reset.err",   32'(rsp_err), 32'd0);
        rst = 1'b0;

        // 1: word store / load
        xact(1, SZ_W, 0, 32'h10, 32'hDEADBEEF); expect_rsp("sw10", 32'h0, 0, 1);
        xact(0, SZ_W, 0, 32'h10, 32'h0);        expect_rsp("lw10", 32'hDEADBEEF, 0, 1);

        // 2: byte store, signed/unsigned byte loads
        xact(1, SZ_B, 0, 32'h11, 32'hFFFFFF80); expect_rsp("sb11", 32'h0, 0, 1);
        xact(0, SZ_B, 1, 32'h11, 32'h0);        expect_rsp("lb11", 32'hFFFFFF80, 0, 1);
        xact(0, SZ_B, 0, 32'h11, 32'h0);        expect_rsp("lbu11", 32'h00000080, 0, 1);
        xact(0, SZ_W, 0, 32'h10, 32'h0);        expect_rsp("lw10b", 32'hDEAD80EF, 0, 1);

        // 3: halfword at offset 1 does not cross
        xact(1, SZ_H, 0, 32'h21, 32'h00008001); expect_rsp("sh21", 32'h0, 0, 1);
        xact(0, SZ_H, 1, 32'h21, 32'h0);        expect_rsp("lh21", 32'hFFFF8001, 0, 1);
        xact(0, SZ_H, 0, 32'h21, 32'h0);        expect_rsp("lhu21", 32'h00008001, 0, 1);

        // 4: word store crossing 0x30/0x34
        xact(1, SZ_W, 0, 32'h30, 32'hAAAAAAAA); expect_rsp("sw30", 32'h0, 0, 1);
        xact(1, SZ_W, 0, 32'h34, 32'h55555555); expect_rsp("sw34", 32'h0, 0, 1);
`ifdef DMEM_MISALIGN_SPLIT_EN
        xact(1, SZ_W, 0, 32'h32, 32'h11223344); expect_rsp("sw32", 32'h0, 0, 2);
        xact(0, SZ_W, 0, 32'h30, 32'h0);        expect_rsp("lw30", 32'h3344AAAA, 0, 1);
        xact(0, SZ_W, 0, 32'h34, 32'h0);        expect_rsp("lw34", 32'h55551122, 0, 1);
        xact(0, SZ_W, 0, 32'h32, 32'h0);        expect_rsp("lw32", 32'h11223344, 0, 2);
        xact(0, SZ_H, 0, 32'h33, 32'h0);        expect_rsp("lhu33", 32'h00002233, 0, 2);
`else
        xact(1, SZ_W, 0, 32'h32, 32'h11223344); expect_rsp("sw32", 32'h0, 1, 1);
        xact(0, SZ_W, 0, 32'h30, 32'h0);        expect_rsp("lw30", 32'hAAAAAAAA, 0, 1);
        xact(0, SZ_W, 0, 32'h34, 32'h0);        expect_rsp("lw34", 32'h55555555, 0, 1);
        xact(0, SZ_W, 0, 32'h32, 32'h0);        expect_rsp("lw32", 32'h0, 1, 1);
        xact(0, SZ_H, 0, 32'h33, 32'h0);        expect_rsp("lhu33", 32'h0, 1, 1);
`endif

        // 5: out-of-range and last-word crossing, no wrap to index 0
        xact(1, SZ_W, 0, 32'h0,   32'h12345678); expect_rsp("sw0", 32'h0, 0, 1);
        xact(1, SZ_W, 0, 32'hFFC, 32'h0BADF00D); expect_rsp("swffc", 32'h0, 0, 1);
        xact(1, SZ_W, 0, 32'h1000, 32'hFFFFFFFF); expect_rsp("sw1000", 32'h0, 1, 1);
        xact(0, SZ_W, 0, 32'h0,   32'h0);        expect_rsp("lw0", 32'h12345678, 0, 1);
        xact(0, SZ_W, 0, 32'h1000, 32'h0);       expect_rsp("lw1000", 32'h0, 1, 1);
        xact(1, SZ_W, 0, 32'hFFE, 32'hFFFFFFFF); expect_rsp("swffe", 32'h0, 1, 1);
        xact(0, SZ_W, 0, 32'hFFC, 32'h0);        expect_rsp("lwffc", 32'h0BADF00D, 0, 1);
        xact(0, SZ_W, 0, 32'h0,   32'h0);        expect_rsp("lw0b", 32'h12345678, 0, 1);

        // 6a: back-to-back aligned loads with req_valid held
        @(negedge clk);
        req_we = 1'b0; req_size = SZ_W; req_signed = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        check("b2b0.valid", 32'(rsp_valid), 32'd1);
        check("b2b0.data",  rsp_rdata, 32'hDEAD80EF);
        check("b2b0.ready", 32'(req_ready), 32'd1);
        @(negedge clk); req_addr = 32'h0;
        @(posedge clk); #1;
        check("b2b1.valid", 32'(rsp_valid), 32'd1);
        check("b2b1.data",  rsp_rdata, 32'h12345678);
        @(negedge clk); req_addr = 32'hFFC;
        @(posedge clk); #1;
        check("b2b2.valid", 32'(rsp_valid), 32'd1);
        check("b2b2.data",  rsp_rdata, 32'h0BADF00D);
        @(negedge clk); req_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b.idle", 32'(rsp_valid), 32'd0);

        // 6b: reset while a crossing store is in progress
        xact(1, SZ_W, 0, 32'h40, 32'h0); expect_rsp("sw40", 32'h0, 0, 1);
        xact(1, SZ_W, 0, 32'h44, 32'h0); expect_rsp("sw44", 32'h0, 0, 1);
        @(negedge clk);
        req_we = 1'b1; req_size = SZ_W; req_addr = 32'h42; req_wdata = 32'hCAFEBABE; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
        check("rst.split_valid", 32'(rsp_valid), 32'd0);
        check("rst.split_ready", 32'(req_ready), 32'd0);
`else
        check("rst.resp_valid", 32'(rsp_valid), 32'd1);
        check("rst.resp_err",   32'(rsp_err), 32'd1);
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst.valid", 32'(rsp_valid), 32'd0);
        check("rst.ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        check("rst.no_rsp", 32'(rsp_valid), 32'd0);
`ifdef DMEM_MISALIGN_SPLIT_EN
        xact(0, SZ_W, 0, 32'h40, 32'h0); expect_rsp("lw40", 32'hBABE0000, 0, 1);
`else
        xact(0, SZ_W, 0, 32'h40, 32'h0); expect_rsp("lw40", 32'h00000000, 0, 1);
`endif
        xact(0, SZ_W, 0, 32'h44, 32'h0); expect_rsp("lw44", 32'h00000000, 0, 1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
